// File: rtl/cast_vc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cast_vc_pkg
// Description : Shared types and constants for the multi-VC cast-router
//               input stage.
//               flit_type_e   - flit type carried in the top bits of a flit.
//               stage_state_e - packet-level state of the input stage.
//               C_FT_W        - width of the type field, which sits in the
//                               top C_FT_W bits of every flit.
// Revision    : 1.0 - initial release
// ============================================================================
package cast_vc_pkg;

  localparam int C_FT_W = 2;

  typedef enum logic [1:0] {
    BODY   = 2'b00,
    HEAD   = 2'b01,
    TAIL   = 2'b10,
    SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_ACTIVE = 2'd2
  } stage_state_e;

  // A flit that may start a packet
  function automatic logic ft_opens(input flit_type_e t);
    return (t == HEAD) || (t == SINGLE);
  endfunction

  // A flit that ends a packet
  function automatic logic ft_closes(input flit_type_e t);
    return (t == TAIL) || (t == SINGLE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cast_vc_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cast_vc_fifo
// Description : Single-VC first-word-fall-through flit buffer.
//               Ports: clk, rstn (async, active-low); i_wr_en/i_wr_data write
//               side (ignored when full); i_rd_en pops the front (ignored
//               when empty); o_rd_data is the current front; o_full,
//               o_empty, o_count give occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module cast_vc_fifo #(
  parameter int DW        = 32,
  parameter int DEPTH_LOG = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_wr_en,
  input  logic [DW-1:0]        i_wr_data,
  input  logic                 i_rd_en,
  output logic [DW-1:0]        o_rd_data,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [DEPTH_LOG:0]   o_count
);

  localparam int              C_DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] C_FULL_CNT = (DEPTH_LOG+1)'(C_DEPTH);

  logic [DW-1:0]        r_mem [C_DEPTH];
  logic [DEPTH_LOG-1:0] r_wr_ptr;
  logic [DEPTH_LOG-1:0] r_rd_ptr;
  logic [DEPTH_LOG:0]   r_count;
  logic                 w_wr;
  logic                 w_rd;

  // A write into a full buffer is refused even if a pop happens in the
  // same cycle: readiness is judged on the registered occupancy only.
  assign w_wr = i_wr_en && (r_count != C_FULL_CNT);
  assign w_rd = i_rd_en && (r_count != '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + DEPTH_LOG'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + DEPTH_LOG'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (DEPTH_LOG+1)'(1);
        2'b01:   r_count <= r_count - (DEPTH_LOG+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_full    = (r_count == C_FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;

endmodule
`default_nettype wire

// File: rtl/cast_vc_input_stage.sv
`default_nettype none
// ============================================================================
// Module      : cast_vc_input_stage
// Description : Multi-VC router input stage. NUM_VC FWFT buffers behind one
//               input link; whole packets are picked round-robin among VCs,
//               an output channel is requested from the VC allocator, and
//               the granted packet is streamed to the crossbar.
//               Ports: valid_i/vc_i/data_i/ready_o  - input link
//                      rt_sid_o/rt_cand_i           - external route lookup
//                      reqVC/selOutVC/VCgranted     - VC allocator
//                      selXBVC/valid_o/vc_o/data_o/ready_i - crossbar side
//                      err_o                        - sticky protocol error
// Revision    : 1.0 - initial release
// ============================================================================
module cast_vc_input_stage
  import cast_vc_pkg::*;
#(
  parameter int DW        = 32,
  parameter int NUM_VC    = 2,
  parameter int VCW       = 1,
  parameter int DEPTH_LOG = 2,
  parameter int CN        = 5,
  parameter int SID_H     = 29,
  parameter int SID_L     = 24
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              valid_i,
  input  logic [VCW-1:0]                    vc_i,
  input  logic [DW-1:0]                     data_i,
  output logic [NUM_VC-1:0]                 ready_o,
  output logic [NUM_VC*(SID_H-SID_L+1)-1:0] rt_sid_o,
  input  logic [NUM_VC*CN-1:0]              rt_cand_i,
  output logic [CN-1:0]                     reqVC,
  input  logic [CN-1:0]                     selOutVC,
  input  logic                              VCgranted,
  output logic [CN-1:0]                     selXBVC,
  output logic                              valid_o,
  output logic [VCW-1:0]                    vc_o,
  output logic [DW-1:0]                     data_o,
  input  logic                              ready_i,
  output logic                              err_o
);

  localparam int                 C_SIDW    = SID_H - SID_L + 1;
  localparam logic [DEPTH_LOG:0] C_CNT_MAX = (DEPTH_LOG+1)'(1 << DEPTH_LOG);

  stage_state_e       r_state;
  logic [VCW-1:0]     r_rr_ptr;
  logic [VCW-1:0]     r_cur_vc;
  logic [CN-1:0]      r_sel_xb;
  logic               r_err;

  logic [NUM_VC-1:0]  w_full;
  logic [NUM_VC-1:0]  w_empty;
  logic [NUM_VC-1:0]  w_wr_en;
  logic [NUM_VC-1:0]  w_rd_en;
  logic [NUM_VC-1:0]  w_cand;
  logic [NUM_VC-1:0]  w_bad;
  logic [DW-1:0]      w_front [NUM_VC];
  logic [DEPTH_LOG:0] w_count [NUM_VC];

  logic               w_any_bad;
  logic               w_any_cand;
  logic [VCW-1:0]     w_drop_vc;
  logic [VCW-1:0]     w_pick_vc;
  logic [VCW-1:0]     w_rr_next;
  logic [CN-1:0]      w_req;
  logic               w_valid;
  logic               w_fire;
  logic               w_last;

  // First candidate at or after ptr, wrapping modulo NUM_VC.
  function automatic logic [VCW-1:0] rr_pick(input logic [NUM_VC-1:0] cand,
                                              input logic [VCW-1:0]    ptr);
    logic [VCW-1:0] sel;
    logic           found;
    int             idx;
    sel   = ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_VC; i++) begin
      idx = (int'(ptr) + i) % NUM_VC;
      if (!found && cand[idx]) begin
        sel   = VCW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  generate
    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
      flit_type_e w_ftype;

      assign w_ftype    = flit_type_e'(w_front[v][DW-1 -: C_FT_W]);
      assign w_wr_en[v] = valid_i && (vc_i == VCW'(v));

      cast_vc_fifo #(
        .DW        (DW),
        .DEPTH_LOG (DEPTH_LOG)
      ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .i_wr_en   (w_wr_en[v]),
        .i_wr_data (data_i),
        .i_rd_en   (w_rd_en[v]),
        .o_rd_data (w_front[v]),
        .o_full    (w_full[v]),
        .o_empty   (w_empty[v]),
        .o_count   (w_count[v])
      );

      // In idle every non-empty front either opens a packet or is an
      // orphan body/tail that has to be flushed.
      assign w_cand[v] = !w_empty[v] && ft_opens(w_ftype);
      assign w_bad[v]  = !w_empty[v] && !ft_opens(w_ftype);

      assign w_rd_en[v] = ((r_state == S_IDLE) && w_any_bad && (w_drop_vc == VCW'(v)))
                       || (w_fire && (r_cur_vc == VCW'(v)));

      assign ready_o[v]                     = !w_full[v];
      assign rt_sid_o[v*C_SIDW +: C_SIDW]   = w_front[v][SID_H:SID_L];

      a_count_bound : assert property (@(posedge clk) disable iff (!rstn)
                                       w_count[v] <= C_CNT_MAX);
    end
  endgenerate

  assign w_any_bad  = |w_bad;
  assign w_any_cand = |w_cand;
  assign w_pick_vc  = rr_pick(w_cand, r_rr_ptr);

  // Lowest-index orphan is flushed first.
  always_comb begin
    w_drop_vc = '0;
    for (int i = NUM_VC - 1; i >= 0; i--) begin
      if (w_bad[i]) w_drop_vc = VCW'(i);
    end
  end

  assign w_rr_next = (r_cur_vc == VCW'(NUM_VC - 1)) ? '0 : r_cur_vc + VCW'(1);
  assign w_req     = rt_cand_i[r_cur_vc*CN +: CN];
  assign w_valid   = (r_state == S_ACTIVE) && !w_empty[r_cur_vc];
  assign w_fire    = w_valid && ready_i;
  assign w_last    = ft_closes(flit_type_e'(w_front[r_cur_vc][DW-1 -: C_FT_W]));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
      r_cur_vc <= '0;
      r_sel_xb <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A flushing cycle does not arbitrate.
          if (w_any_bad) begin
            r_err <= 1'b1;
          end else if (w_any_cand) begin
            r_cur_vc <= w_pick_vc;
            r_state  <= S_REQ;
          end
        end
        S_REQ: begin
          // A grant against an empty candidate set is not a real grant.
          if (VCgranted && (w_req != '0)) begin
            r_sel_xb <= selOutVC;
            r_state  <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (w_fire && w_last) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= w_rr_next;
            r_sel_xb <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign reqVC   = (r_state == S_REQ) ? w_req : '0;
  assign selXBVC = r_sel_xb;
  assign valid_o = w_valid;
  assign vc_o    = r_cur_vc;
  assign data_o  = w_front[r_cur_vc];
  assign err_o   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cast_vc_input_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_cast_vc_input_stage
// Description : Self-checking bench for cast_vc_input_stage. Written flits
//               are pushed to per-VC expected queues, the expected packet
//               order to an order queue; flits are popped and compared as
//               the stage emits them. The route table and the allocator are
//               modelled in the bench.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cast_vc_input_stage;

  localparam int DW = 32, NUM_VC = 2, VCW = 1, DEPTH_LOG = 2, CN = 5;
  localparam int SID_H = 29, SID_L = 24;
  localparam int SW = SID_H - SID_L + 1;

  localparam logic [1:0] FT_BODY = 2'b00, FT_HEAD = 2'b01,
                         FT_TAIL = 2'b10, FT_SINGLE = 2'b11;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 valid_i;
  logic [VCW-1:0]       vc_i;
  logic [DW-1:0]        data_i;
  logic [NUM_VC-1:0]    ready_o;
  logic [NUM_VC*SW-1:0] rt_sid_o;
  logic [NUM_VC*CN-1:0] rt_cand_i;
  logic [CN-1:0]        reqVC;
  logic [CN-1:0]        selOutVC;
  logic                 VCgranted;
  logic [CN-1:0]        selXBVC;
  logic                 valid_o;
  logic [VCW-1:0]       vc_o;
  logic [DW-1:0]        data_o;
  logic                 ready_i;
  logic                 err_o;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  int          exp_order[$];
  logic        own_valid = 1'b0;
  int          own_vc = 0;

  always #5 clk = ~clk;

  // Route table model: stream ID selects one output, sid mod CN.
  function automatic logic [CN-1:0] route(input logic [SW-1:0] sid);
    return CN'(1) << (int'(sid) % CN);
  endfunction

  assign rt_cand_i = {route(rt_sid_o[SW +: SW]), route(rt_sid_o[0 +: SW])};

  cast_vc_input_stage #(
    .DW(DW), .NUM_VC(NUM_VC), .VCW(VCW), .DEPTH_LOG(DEPTH_LOG),
    .CN(CN), .SID_H(SID_H), .SID_L(SID_L)
  ) dut (
    .clk(clk), .rstn(rstn), .valid_i(valid_i), .vc_i(vc_i), .data_i(data_i),
    .ready_o(ready_o), .rt_sid_o(rt_sid_o), .rt_cand_i(rt_cand_i),
    .reqVC(reqVC), .selOutVC(selOutVC), .VCgranted(VCgranted),
    .selXBVC(selXBVC), .valid_o(valid_o), .vc_o(vc_o), .data_o(data_o),
    .ready_i(ready_i), .err_o(err_o)
  );

  function automatic logic [31:0] mk(input logic [1:0] ft, input logic [5:0] sid,
                                     input logic [23:0] pay);
    return {ft, sid, pay};
  endfunction

  // Drive one flit for one cycle; it is expected out only if the link is
  // ready and keep is set.
  task automatic send(input int vc, input logic [1:0] ft, input logic [5:0] sid,
                      input logic [23:0] pay, input logic keep);
    logic [31:0] d;
    d       = mk(ft, sid, pay);
    valid_i = 1'b1;
    vc_i    = VCW'(vc);
    data_i  = d;
    if (ready_o[vc] && keep) begin
      if (vc == 0) exp_q0.push_back(d);
      else         exp_q1.push_back(d);
    end
    @(negedge clk);
  endtask

  // Accept flits with ready_i high and grant every request immediately;
  // compare each emitted flit with the scoreboard.
  task automatic drain(input int n, input int budget);
    int          got;
    int          cyc;
    logic [31:0] exp_d;
    logic        have;
    got = 0; cyc = 0;
    ready_i = 1'b1;
    valid_i = 1'b0;
    while (got < n && cyc < budget) begin
      if (valid_o) begin
        if (!own_valid) begin
          checks++;
          if (exp_order.size() == 0) begin
            errors++;
            $display("FAIL pkt_order: unexpected packet on vc %0d, none required", vc_o);
            own_vc = int'(vc_o);
          end else begin
            own_vc = exp_order.pop_front();
          end
          own_valid = 1'b1;
        end
        checks++;
        if (vc_o !== VCW'(own_vc)) begin
          errors++;
          $display("FAIL vc_o: got %0d required %0d", vc_o, own_vc);
        end
        have = 1'b0;
        exp_d = '0;
        if (own_vc == 0 && exp_q0.size() > 0) begin exp_d = exp_q0.pop_front(); have = 1'b1; end
        if (own_vc == 1 && exp_q1.size() > 0) begin exp_d = exp_q1.pop_front(); have = 1'b1; end
        checks++;
        if (!have || data_o !== exp_d) begin
          errors++;
          $display("FAIL data_o: got %h required %h (expected available=%0d)", data_o, exp_d, have);
        end
        if (exp_d[31]) own_valid = 1'b0;
        got++;
      end
      if (reqVC != '0) begin
        VCgranted = 1'b1;
        selOutVC  = reqVC & (~reqVC + CN'(1));
      end else begin
        VCgranted = 1'b0;
        selOutVC  = '0;
      end
      @(negedge clk);
      cyc++;
    end
    VCgranted = 1'b0;
    selOutVC  = '0;
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL drain_timeout: got %0d flits required %0d", got, n);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (valid_o !== 1'b0 || reqVC !== '0 || ready_o !== 2'b11 || err_o !== 1'b0 ||
        selXBVC !== '0 || vc_o !== '0) begin
      errors++;
      $display("FAIL reset_vals: valid=%b req=%b ready=%b err=%b sel=%b vc=%0d required 0,0,11,0,0,0",
               valid_o, reqVC, ready_o, err_o, selXBVC, vc_o);
    end
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (ready_o !== 2'b11 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: ready=%b valid=%b required 11 0", ready_o, valid_o);
    end
  endtask

  task automatic test_single_vc();
    ready_i = 1'b0;
    exp_order.push_back(0);
    send(0, FT_HEAD, 6'd2, 24'h000A01, 1'b1);
    checks++;
    if (reqVC !== 5'b00000) begin
      errors++;
      $display("FAIL req_early: got %b required 00000", reqVC);
    end
    send(0, FT_BODY, 6'd2, 24'h000A02, 1'b1);
    checks++;
    if (reqVC !== 5'b00100) begin
      errors++;
      $display("FAIL req_latency: got %b required 00100", reqVC);
    end
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL valid_early: got %b required 0", valid_o);
    end
    VCgranted = 1'b1;
    selOutVC  = 5'b00100;
    send(0, FT_TAIL, 6'd2, 24'h000A03, 1'b1);
    VCgranted = 1'b0;
    selOutVC  = '0;
    valid_i   = 1'b0;
    checks++;
    if (valid_o !== 1'b1 || selXBVC !== 5'b00100) begin
      errors++;
      $display("FAIL valid_latency: valid=%b sel=%b required 1 00100", valid_o, selXBVC);
    end
    drain(3, 20);
    checks++;
    if (selXBVC !== '0 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL sel_clear: sel=%b valid=%b required 00000 0", selXBVC, valid_o);
    end
  endtask

  task automatic test_interleaved();
    exp_order.push_back(0);
    exp_order.push_back(1);
    ready_i = 1'b0;
    send(0, FT_HEAD, 6'd1, 24'h000B01, 1'b1);
    send(1, FT_HEAD, 6'd4, 24'h000C01, 1'b1);
    send(0, FT_BODY, 6'd1, 24'h000B02, 1'b1);
    send(1, FT_BODY, 6'd4, 24'h000C02, 1'b1);
    send(0, FT_TAIL, 6'd1, 24'h000B03, 1'b1);
    send(1, FT_TAIL, 6'd4, 24'h000C03, 1'b1);
    drain(6, 100);
    // After VC0 finishes, both VCs hold a packet: round-robin must take VC1.
    exp_order.push_back(0);
    exp_order.push_back(1);
    exp_order.push_back(0);
    ready_i = 1'b0;
    send(0, FT_HEAD,   6'd3, 24'h000D01, 1'b1);
    send(1, FT_SINGLE, 6'd0, 24'h000E01, 1'b1);
    send(0, FT_TAIL,   6'd3, 24'h000D02, 1'b1);
    send(0, FT_SINGLE, 6'd1, 24'h000F01, 1'b1);
    drain(4, 100);
  endtask

  task automatic test_backpressure_full();
    ready_i = 1'b0;
    exp_order.push_back(1);
    send(1, FT_HEAD, 6'd5, 24'h001001, 1'b1);
    send(1, FT_BODY, 6'd5, 24'h001002, 1'b1);
    send(1, FT_BODY, 6'd5, 24'h001003, 1'b1);
    send(1, FT_TAIL, 6'd5, 24'h001004, 1'b1);
    checks++;
    if (ready_o !== 2'b01) begin
      errors++;
      $display("FAIL full_ready: got %b required 01", ready_o);
    end
    send(1, FT_BODY, 6'd5, 24'h001005, 1'b1);
    drain(4, 50);
    repeat (3) @(negedge clk);
    checks++;
    if (valid_o !== 1'b0 || err_o !== 1'b0 || reqVC !== '0) begin
      errors++;
      $display("FAIL full_drop: valid=%b err=%b req=%b required 0 0 00000", valid_o, err_o, reqVC);
    end
  endtask

  task automatic test_grant_delay();
    int w;
    ready_i = 1'b0;
    exp_order.push_back(0);
    send(0, FT_HEAD, 6'd3, 24'h002001, 1'b1);
    send(0, FT_TAIL, 6'd3, 24'h002002, 1'b1);
    valid_i = 1'b0;
    w = 0;
    while (reqVC == '0 && w < 10) begin
      @(negedge clk);
      w++;
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (reqVC !== 5'b01000 || valid_o !== 1'b0) begin
        errors++;
        $display("FAIL grant_wait: cycle %0d req=%b valid=%b required 01000 0", k, reqVC, valid_o);
      end
      @(negedge clk);
    end
    VCgranted = 1'b1;
    selOutVC  = 5'b01000;
    @(negedge clk);
    VCgranted = 1'b0;
    selOutVC  = '0;
    checks++;
    if (valid_o !== 1'b1 || selXBVC !== 5'b01000) begin
      errors++;
      $display("FAIL grant_start: valid=%b sel=%b required 1 01000", valid_o, selXBVC);
    end
    drain(2, 20);
  endtask

  task automatic test_protocol_error();
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("FAIL err_pre: got %b required 0", err_o);
    end
    send(1, FT_BODY, 6'd2, 24'h003001, 1'b0);
    valid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (reqVC !== '0 || valid_o !== 1'b0) begin
        errors++;
        $display("FAIL err_quiet: cycle %0d req=%b valid=%b required 00000 0", k, reqVC, valid_o);
      end
      @(negedge clk);
    end
    checks++;
    if (err_o !== 1'b1) begin
      errors++;
      $display("FAIL err_set: got %b required 1", err_o);
    end
    exp_order.push_back(1);
    send(1, FT_SINGLE, 6'd4, 24'h003002, 1'b1);
    drain(1, 20);
    checks++;
    if (err_o !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b required 1", err_o);
    end
  endtask

  task automatic test_reset_mid_packet();
    int w;
    ready_i = 1'b0;
    exp_order.push_back(0);
    send(0, FT_HEAD, 6'd2, 24'h004001, 1'b1);
    send(0, FT_BODY, 6'd2, 24'h004002, 1'b1);
    send(0, FT_BODY, 6'd2, 24'h004003, 1'b1);
    send(0, FT_TAIL, 6'd2, 24'h004004, 1'b1);
    valid_i = 1'b0;
    drain(2, 30);
    ready_i = 1'b0;
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0 || reqVC !== '0 || ready_o !== 2'b11 || selXBVC !== '0 ||
        err_o !== 1'b0 || vc_o !== '0) begin
      errors++;
      $display("FAIL async_reset: valid=%b req=%b ready=%b sel=%b err=%b vc=%0d required 0,0,11,0,0,0",
               valid_o, reqVC, ready_o, selXBVC, err_o, vc_o);
    end
    exp_q0.delete();
    exp_q1.delete();
    exp_order.delete();
    own_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    exp_order.push_back(0);
    send(0, FT_SINGLE, 6'd2, 24'h005001, 1'b1);
    drain(1, 20);
    w = 0;
    repeat (3) begin
      if (valid_o) w++;
      @(negedge clk);
    end
    checks++;
    if (w != 0 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_flush: stale valid cycles=%0d err=%b required 0 0", w, err_o);
    end
  endtask

  initial begin
    rstn      = 1'b0;
    valid_i   = 1'b0;
    vc_i      = '0;
    data_i    = '0;
    selOutVC  = '0;
    VCgranted = 1'b0;
    ready_i   = 1'b0;
    test_reset();
    test_single_vc();
    test_interleaved();
    test_backpressure_full();
    test_grant_delay();
    test_protocol_error();
    test_reset_mid_packet();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cast_vc_input_stage.md
Name: cast_vc_input_stage

Overview:
Multi-VC successor of the cast-router input stage. Holds NUM_VC independent FWFT flit buffers behind one physical input link, arbitrates whole packets among VCs (round-robin), requests an output channel from the VC allocator for the winning packet, then streams it to the crossbar. Route lookup stays external: a stream ID goes out, candidate outputs come back combinationally. One instance per router input port.

Parameters:
DW, 32, flit width; bits [DW-1:DW-2] are flit type.
NUM_VC, 2, virtual channels per input port (>=2).
VCW, 1, VC index width, equal to clog2(NUM_VC).
DEPTH_LOG, 2, log2 of per-VC buffer depth.
CN, 5, output channel count.
SID_H, 29, stream-ID field MSB.
SID_L, 24, stream-ID field LSB.

Ports:
clk  in  1  clock
rstn  in  1  reset; asynchronous, active-low
valid_i  in  1  input flit valid
vc_i  in  VCW  target VC of input flit
data_i  in  DW  input flit
ready_o  out  NUM_VC  per-VC buffer not full
rt_sid_o  out  NUM_VC*(SID_H-SID_L+1)  stream ID at each VC buffer front
rt_cand_i  in  NUM_VC*CN  candidate outputs per VC (combinational from table)
reqVC  out  CN  request to VC allocator
selOutVC  in  CN  granted output (one-hot)
VCgranted  in  1  allocator grant
selXBVC  out  CN  crossbar select
valid_o  out  1  output flit valid
vc_o  out  VCW  VC of current output flit
data_o  out  DW  output flit
ready_i  in  1  downstream accept
err_o  out  1  sticky protocol error

Behaviour:
- Flit types: 2'b00 BODY, 2'b01 HEAD, 2'b10 TAIL, 2'b11 SINGLE (head and tail).
- Write: fifo[vc_i] written when valid_i & ready_o[vc_i]. ready_o[v] = ~full[v]. No write bypass when full, even if a read occurs in the same cycle.
- FWFT: a flit written at cycle t is at the front at t+1. Simultaneous read and write on a non-full buffer are both honoured.
- Stage FSM:
  - S_IDLE: Candidates are VCs whose front is HEAD or SINGLE. Pick one round-robin starting at rr_ptr. Latch cur_vc. Go to S_REQ on the next cycle.
  - S_REQ: reqVC = rt_cand_i[cur_vc]. On VCgranted, latch selOutVC into selXBVC and go to S_ACTIVE. reqVC holds until grant.
  - S_ACTIVE: valid_o = ~empty[cur_vc], and does not depend on ready_i. fire = valid_o & ready_i pops fifo[cur_vc]. When a TAIL or SINGLE flit fires: go to S_IDLE, set rr_ptr = cur_vc+1 mod NUM_VC, clear selXBVC.
- Latency: HEAD written at t → reqVC at t+2 → with same-cycle grant, valid_o at t+3.
- BODY or TAIL at the front of a non-owner VC while in S_IDLE: popped, dropped, err_o set. When several VCs are in this state, the lowest index is popped first, one per cycle. No arbitration happens in a cycle that drops.
- VCgranted outside S_REQ is ignored.
- rt_cand_i equal to zero in S_REQ: the stage stays in S_REQ. The allocator must not grant.
- Only cur_vc is ever read while a packet is owned. Other VCs keep accepting writes until full.
- Reset values: all buffers empty; FSM S_IDLE; rr_ptr=0; cur_vc=0; reqVC=0; selXBVC=0; valid_o=0; vc_o=0; err_o=0; ready_o all ones. data_o is don't-care while valid_o=0.
- Reset asserted mid-packet discards all buffered flits immediately. Outputs take their reset values asynchronously.
- Pointer arithmetic is DEPTH_LOG bits and wraps naturally. Occupancy is DEPTH_LOG+1 bits.

Decomposition:
- Package cast_vc_pkg holds: flit_type_e enum (BODY/HEAD/TAIL/SINGLE), stage_state_e (S_IDLE/S_REQ/S_ACTIVE), and the flit-type field position constants.
- Sub-module cast_vc_fifo: a single-VC FWFT buffer with full, empty and count. The stage instantiates NUM_VC of them in a generate loop.
- The round-robin picker is an in-module function.

Test Plan:
- Single-VC packet: HEAD/BODY/TAIL on VC0 at t=0..2, rt_cand_i[0]=5'b00100, grant at first reqVC cycle. Expect reqVC=5'b00100 at t=2, valid_o at t=3, three flits out in order, selXBVC cleared after the TAIL fire.
- Interleaved VCs: VC0 and VC1 each get a 3-flit packet, written alternately. Expect VC0's packet fully first, then VC1's with no interleaving, and rr_ptr=1 then 0.
- Backpressure and full: ready_i=0 while 5 flits go to VC1 with DEPTH_LOG=2. Expect ready_o[1]=0 after 4 writes, the 5th dropped by the source, and ready_o[0] still 1.
- Grant delay: hold VCgranted low for 6 cycles. Expect reqVC stable and valid_o=0 throughout, then streaming starts the cycle after the grant.
- Protocol error: a lone BODY flit to VC1 while idle. Expect it popped, err_o=1 and staying high, and no reqVC.
- Reset mid-packet: deassert rstn after 2 of 4 flits are out. Expect immediate valid_o=0, reqVC=0 and ready_o all ones; after reset, a fresh SINGLE flit passes normally.
